// File: rtl/cpu_io_pkg.sv
// Shared types and sizes for the CPU external-input serial port.
package cpu_io_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned BIT_W  = $clog2(DATA_W);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    WAITHI = 3'd4
  } state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Metastability filter; reset value matches the line's idle level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_in_port.sv
// 8N1 serial receiver holding the last good byte for the CPU input bus.
module uart_in_port
  import cpu_io_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned CNT_W        = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  input  logic              ack,
  output logic [DATA_W-1:0] inext,
  output logic              valid,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W - 1);

  logic rx_s;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [BIT_W-1:0]  bit_idx, bit_nxt;
  logic [DATA_W-1:0] shreg, sh_nxt;
  logic              load_pend, load_nxt;
  logic [DATA_W-1:0] inext_nxt;
  logic              valid_nxt, fe_nxt, ov_nxt, busy_nxt;
  logic              fe_set;

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  // State, timing and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      load_pend <= 1'b0;
      inext     <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_idx   <= bit_nxt;
      shreg     <= sh_nxt;
      load_pend <= load_nxt;
      inext     <= inext_nxt;
      valid     <= valid_nxt;
      frame_err <= fe_nxt;
      overrun   <= ov_nxt;
      busy      <= busy_nxt;
    end
  end

  // Frame sequencing, bit sampling and CPU-side flag handling.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    bit_nxt   = bit_idx;
    sh_nxt    = shreg;
    load_nxt  = 1'b0;
    fe_set    = 1'b0;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) state_nxt = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt = '0;
          bit_nxt = '0;
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == FULL_LAST) begin
          cnt_nxt = '0;
          sh_nxt  = {rx_s, shreg[DATA_W-1:1]};
          if (bit_idx == LAST_BIT) state_nxt = STOP;
          else                     bit_nxt   = bit_idx + BIT_W'(1);
        end
      end
      STOP: begin
        if (cnt == FULL_LAST) begin
          cnt_nxt = '0;
          if (rx_s) begin
            state_nxt = IDLE;
            load_nxt  = 1'b1;
          end else begin
            state_nxt = WAITHI;
            fe_set    = 1'b1;
          end
        end
      end
      WAITHI: begin
        cnt_nxt = '0;
        if (rx_s) state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase

    inext_nxt = inext;
    valid_nxt = valid;
    fe_nxt    = frame_err;
    ov_nxt    = overrun;
    if (ack) begin
      valid_nxt = 1'b0;
      fe_nxt    = 1'b0;
      ov_nxt    = 1'b0;
    end
    // A load one cycle after a good stop sample; new flags win over ack.
    if (load_pend) begin
      inext_nxt = shreg;
      valid_nxt = 1'b1;
      if (valid && !ack) ov_nxt = 1'b1;
    end
    if (fe_set) fe_nxt = 1'b1;

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_uart_in_port.sv
// Directed bench for uart_in_port with 4 clocks per bit.
module tb_uart_in_port;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       ack;
  logic [7:0] inext;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_checks = 0;
  int n_fails  = 0;

  uart_in_port #(.CLKS_PER_BIT(4), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .rx        (rx),
    .ack       (ack),
    .inext     (inext),
    .valid     (valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start bit, 8 data bits LSB first, stop bit; 4 clocks each.
  task automatic send(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (4) tick();
    end
    rx = stop;
    repeat (4) tick();
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] d, input logic v,
                         input logic fe, input logic ov, input logic bz);
    chk({tag, ".inext"}, inext, d);
    chk({tag, ".valid"}, 8'(valid), 8'(v));
    chk({tag, ".frame_err"}, 8'(frame_err), 8'(fe));
    chk({tag, ".overrun"}, 8'(overrun), 8'(ov));
    chk({tag, ".busy"}, 8'(busy), 8'(bz));
  endtask

  initial begin
    rx    = 1'b1;
    ack   = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (100) tick();
    chk_all("idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Good byte; valid appears exactly one clock after the stop sample.
    send(8'hA5, 1'b1);
    tick();
    chk("a5_stop_edge_valid", 8'(valid), 8'h0);
    tick();
    chk_all("a5_loaded", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_ack();
    chk_all("a5_acked", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) tick();

    // Overrun: second byte loads while first is unread.
    send(8'h3C, 1'b1);
    repeat (5) tick();
    chk_all("3c_loaded", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    send(8'hC3, 1'b1);
    repeat (2) tick();
    chk_all("c3_overrun", 8'hC3, 1'b1, 1'b0, 1'b1, 1'b0);
    pulse_ack();
    chk_all("c3_acked", 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) tick();

    // Framing error followed by a held-low line.
    send(8'h0F, 1'b0);
    rx = 1'b0;
    repeat (40) tick();
    chk_all("break_held", 8'hC3, 1'b0, 1'b1, 1'b0, 1'b1);
    rx = 1'b1;
    tick();
    chk("break_release_busy1", 8'(busy), 8'h1);
    repeat (2) tick();
    chk("break_release_busy0", 8'(busy), 8'h0);
    repeat (5) tick();
    send(8'h55, 1'b1);
    repeat (2) tick();
    chk_all("55_after_break", 8'h55, 1'b1, 1'b1, 1'b0, 1'b0);
    pulse_ack();
    chk_all("55_acked", 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) tick();

    // One-clock low glitch enters START then falls back to IDLE.
    rx = 1'b0;
    tick();
    rx = 1'b1;
    repeat (2) tick();
    chk("glitch_start_busy", 8'(busy), 8'h1);
    repeat (2) tick();
    chk_all("glitch_rejected", 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (10) tick();

    // Reset in the middle of a data bit with a byte pending.
    send(8'h96, 1'b1);
    repeat (5) tick();
    chk_all("96_loaded", 8'h96, 1'b1, 1'b0, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (4) tick();
    rx = 1'b1;
    repeat (4) tick();
    rx = 1'b0;
    repeat (2) tick();
    chk("mid_data_busy", 8'(busy), 8'h1);
    rst_n = 1'b0;
    #1;
    chk_all("async_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    rx = 1'b1;
    repeat (10) tick();
    chk_all("post_reset_idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'h81, 1'b1);
    repeat (2) tick();
    chk_all("81_loaded", 8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_ack();
    repeat (5) tick();

    // ack coincident with the second load: no overrun, new byte shown.
    send(8'h11, 1'b1);
    repeat (5) tick();
    chk_all("11_loaded", 8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    send(8'h22, 1'b1);
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk_all("22_ack_same_cycle", 8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_ack();
    chk_all("22_acked", 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
